// File: rtl/tlc_pkg.sv
// Shared types for the two-road traffic light controller: state codes,
// lamp encodings and the state-to-lamp decode.
// Build option: TLC_NIGHT_FLASH_EN (night flashing mode, used by the top).
package tlc_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAMP_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    HW_G  = 3'd0,
    HW_Y  = 3'd1,
    AR1   = 3'd2,
    LR_G  = 3'd3,
    LR_Y  = 3'd4,
    AR2   = 3'd5,
    NIGHT = 3'd6
  } tlc_state_e;

  localparam logic [LAMP_W-1:0] LAMP_GREEN  = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_YELLOW = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_RED    = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_DARK   = 3'b000;

  typedef struct packed {
    logic [LAMP_W-1:0] hw;
    logic [LAMP_W-1:0] lr;
  } lamp_pair_t;

  // Lamp pair for a state; NIGHT returns its lit phase, blanking is done by the caller.
  // Any code outside the known set decodes to all-red.
  function automatic lamp_pair_t state_lamps(input tlc_state_e s);
    lamp_pair_t p;
    p.hw = LAMP_RED;
    p.lr = LAMP_RED;
    case (s)
      HW_G:    p.hw = LAMP_GREEN;
      HW_Y:    p.hw = LAMP_YELLOW;
      LR_G:    p.lr = LAMP_GREEN;
      LR_Y:    p.lr = LAMP_YELLOW;
      NIGHT:   p.hw = LAMP_YELLOW;
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: loads to 1, counts up while held, saturates at the supplied limit.
module tlc_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] thresh,
  output logic             at_limit_c,
  output logic             ge_thresh_c
);

  logic [CNT_W-1:0] count;

  // Count register: reload on phase entry, otherwise climb up to the limit and hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= CNT_W'(1);
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (count < limit) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_limit_c  = (count >= limit);
  assign ge_thresh_c = (count >= thresh);

endmodule

// File: rtl/tlc_param_controller.sv
// Parametrised highway / local-road traffic light controller with local-road
// gap-out and configurable phase durations.
// Build option: TLC_NIGHT_FLASH_EN enables the night flashing mode (NIGHT state).
module tlc_param_controller
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned HW_GREEN_MIN = 80,
  parameter int unsigned YELLOW_T     = 20,
  parameter int unsigned ALLRED_T     = 1,
  parameter int unsigned LR_GREEN_MIN = 20,
  parameter int unsigned LR_GREEN_MAX = 80,
  parameter int unsigned FLASH_T      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lr_has_car,
  input  logic               night_req,
  output logic [LAMP_W-1:0]  hw_light,
  output logic [LAMP_W-1:0]  lr_light,
  output logic [STATE_W-1:0] state_o
);

`ifdef TLC_NIGHT_FLASH_EN
  localparam logic NIGHT_EN = 1'b1;
`else
  localparam logic NIGHT_EN = 1'b0;
`endif

  tlc_state_e       state;
  tlc_state_e       state_n;
  logic             flash;
  logic             flash_n;
  logic             load_c;
  logic [CNT_W-1:0] limit_c;
  logic             at_limit_c;
  logic             ge_thresh_c;
  logic             night_c;
  lamp_pair_t       lamps_c;

  // Night request only has an effect when the night mode is built in.
  assign night_c = NIGHT_EN & night_req;

  tlc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_c),
    .limit       (limit_c),
    .thresh      (CNT_W'(LR_GREEN_MIN)),
    .at_limit_c  (at_limit_c),
    .ge_thresh_c (ge_thresh_c)
  );

  // Timer limit for the current phase (also the HW_G saturation point).
  always_comb begin
    limit_c = CNT_W'(ALLRED_T);
    case (state)
      HW_G:    limit_c = CNT_W'(HW_GREEN_MIN);
      HW_Y:    limit_c = CNT_W'(YELLOW_T);
      LR_G:    limit_c = CNT_W'(LR_GREEN_MAX);
      LR_Y:    limit_c = CNT_W'(YELLOW_T);
      NIGHT:   limit_c = CNT_W'(FLASH_T);
      default: limit_c = CNT_W'(ALLRED_T);
    endcase
  end

  // Next-state, timer reload and flash phase; any state change reloads the timer.
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    flash_n = flash;
    case (state)
      HW_G: begin
        if (at_limit_c && (lr_has_car || night_c)) begin
          state_n = HW_Y;
          load_c  = 1'b1;
        end
      end
      HW_Y: begin
        if (at_limit_c) begin
          state_n = AR1;
          load_c  = 1'b1;
        end
      end
      AR1: begin
        if (at_limit_c) begin
          state_n = night_c ? NIGHT : LR_G;
          flash_n = 1'b1;
          load_c  = 1'b1;
        end
      end
      LR_G: begin
        // Max-out and gap-out lead to the same place, so no priority is needed.
        if (at_limit_c || (ge_thresh_c && !lr_has_car)) begin
          state_n = LR_Y;
          load_c  = 1'b1;
        end
      end
      LR_Y: begin
        if (at_limit_c) begin
          state_n = AR2;
          load_c  = 1'b1;
        end
      end
      AR2: begin
        if (at_limit_c) begin
          state_n = night_c ? NIGHT : HW_G;
          flash_n = 1'b1;
          load_c  = 1'b1;
        end
      end
`ifdef TLC_NIGHT_FLASH_EN
      NIGHT: begin
        if (!night_req) begin
          state_n = AR2;
          load_c  = 1'b1;
        end else if (at_limit_c) begin
          flash_n = ~flash;
          load_c  = 1'b1;
        end
      end
`endif
      default: begin
        state_n = AR2;
        load_c  = 1'b1;
      end
    endcase
  end

  // Lamp decode from the next state so lamps change on the same edge as the state.
  always_comb begin
    lamps_c = state_lamps(state_n);
    if (state_n == NIGHT && !flash_n) begin
      lamps_c.hw = LAMP_DARK;
      lamps_c.lr = LAMP_DARK;
    end
  end

  // State, flash phase and lamp registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HW_G;
      flash    <= 1'b0;
      hw_light <= LAMP_GREEN;
      lr_light <= LAMP_RED;
    end else begin
      state    <= state_n;
      flash    <= flash_n;
      hw_light <= lamps_c.hw;
      lr_light <= lamps_c.lr;
    end
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_tlc_param_controller.sv
// Self-checking bench for tlc_param_controller: directed vector table,
// hand-written corner sequences and random stimulus against a phase/age model.
module tb_tlc_param_controller;

  localparam int HW_MIN = 80;
  localparam int YEL    = 20;
  localparam int ALLR   = 1;
  localparam int LR_MIN = 20;
  localparam int LR_MAX = 80;
  localparam int FL     = 8;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] D = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lr_has_car = 1'b0;
  logic       night_req = 1'b0;
  logic [2:0] hw_light;
  logic [2:0] lr_light;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase number and how many cycles it has been occupied (1 = first cycle).
  int m_phase = 0;
  int m_age = 1;

  typedef struct {
    string      name;
    logic       rst;
    logic       car;
    logic       night;
    int         cycles;
    logic [2:0] hw;
    logic [2:0] lr;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  tlc_param_controller #(
    .CNT_W        (8),
    .HW_GREEN_MIN (HW_MIN),
    .YELLOW_T     (YEL),
    .ALLRED_T     (ALLR),
    .LR_GREEN_MIN (LR_MIN),
    .LR_GREEN_MAX (LR_MAX),
    .FLASH_T      (FL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lr_has_car (lr_has_car),
    .night_req  (night_req),
    .hw_light   (hw_light),
    .lr_light   (lr_light),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  function automatic bit night_on();
`ifdef TLC_NIGHT_FLASH_EN
    return night_req;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int nxt;
    nxt = m_phase;
    if (!rst_n) begin
      m_phase = 0;
      m_age = 1;
      return;
    end
    case (m_phase)
      0: if (m_age >= HW_MIN && (lr_has_car || night_on())) nxt = 1;
      1: if (m_age == YEL) nxt = 2;
      2: if (m_age == ALLR) nxt = night_on() ? 6 : 3;
      3: if (m_age == LR_MAX || (m_age >= LR_MIN && !lr_has_car)) nxt = 4;
      4: if (m_age == YEL) nxt = 5;
      5: if (m_age == ALLR) nxt = night_on() ? 6 : 0;
      6: if (!night_on()) nxt = 5;
      default: nxt = 5;
    endcase
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_age = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_exp(input string tag, input logic [2:0] ehw,
                           input logic [2:0] elr, input logic [2:0] est);
    vectors++;
    if (hw_light !== ehw || lr_light !== elr || state_o !== est) begin
      miscompares++;
      $display("FAIL %s: got hw=%b lr=%b state=%0d, want hw=%b lr=%b state=%0d",
               tag, hw_light, lr_light, state_o, ehw, elr, est);
    end
  endtask

  task automatic check_model(input string tag);
    logic [2:0] ehw;
    logic [2:0] elr;
    case (m_phase)
      0: begin ehw = G; elr = R; end
      1: begin ehw = Y; elr = R; end
      3: begin ehw = R; elr = G; end
      4: begin ehw = R; elr = Y; end
      6: begin
        if (((m_age - 1) / FL) % 2 == 0) begin ehw = Y; elr = R; end
        else begin ehw = D; elr = D; end
      end
      default: begin ehw = R; elr = R; end
    endcase
    check_exp({tag, "_model"}, ehw, elr, 3'(m_phase));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lr_has_car = 1'b0;
    night_req = 1'b0;
    tick("reset");
    rst_n = 1'b1;
  endtask

  function automatic void add(input string n, input logic r, input logic c,
                              input logic ng, input int cy, input logic [2:0] h,
                              input logic [2:0] l, input logic [2:0] s);
    vec_t v;
    v.name = n; v.rst = r; v.car = c; v.night = ng; v.cycles = cy;
    v.hw = h; v.lr = l; v.st = s;
    tbl.push_back(v);
  endfunction

  initial begin
    // Idle highway, then one full cycle with a car held from reset.
    add("reset_hold",   1'b0, 1'b0, 1'b0, 3,    G, R, 3'd0);
    add("idle_1000",    1'b1, 1'b0, 1'b0, 1000, G, R, 3'd0);
    add("reset2",       1'b0, 1'b0, 1'b0, 1,    G, R, 3'd0);
    add("hw_g_min",     1'b1, 1'b1, 1'b0, 79,   G, R, 3'd0);
    add("hw_y_enter",   1'b1, 1'b1, 1'b0, 1,    Y, R, 3'd1);
    add("hw_y_hold",    1'b1, 1'b1, 1'b0, 19,   Y, R, 3'd1);
    add("ar1",          1'b1, 1'b1, 1'b0, 1,    R, R, 3'd2);
    add("lr_g_enter",   1'b1, 1'b1, 1'b0, 1,    R, G, 3'd3);
    add("lr_g_hold",    1'b1, 1'b1, 1'b0, 79,   R, G, 3'd3);
    add("lr_maxout",    1'b1, 1'b1, 1'b0, 1,    R, Y, 3'd4);
    add("lr_y_hold",    1'b1, 1'b1, 1'b0, 19,   R, Y, 3'd4);
    add("ar2",          1'b1, 1'b1, 1'b0, 1,    R, R, 3'd5);
    add("hw_g_again",   1'b1, 1'b1, 1'b0, 1,    G, R, 3'd0);
    add("hw_g_cycle2",  1'b1, 1'b1, 1'b0, 79,   G, R, 3'd0);
    add("hw_y_cycle2",  1'b1, 1'b1, 1'b0, 1,    Y, R, 3'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      rst_n = tbl[k].rst;
      lr_has_car = tbl[k].car;
      night_req = tbl[k].night;
      run(tbl[k].cycles, tbl[k].name);
      check_exp(tbl[k].name, tbl[k].hw, tbl[k].lr, tbl[k].st);
    end

    // Gap-out at LR_G timer 30.
    do_reset();
    lr_has_car = 1'b1;
    run(130, "t3");
    check_exp("t3_lr_g_t30", R, G, 3'd3);
    lr_has_car = 1'b0;
    run(1, "t3");
    check_exp("t3_gapout", R, Y, 3'd4);

    // Car leaves early: green held to the minimum.
    do_reset();
    lr_has_car = 1'b1;
    run(105, "t4");
    lr_has_car = 1'b0;
    run(15, "t4");
    check_exp("t4_min_hold", R, G, 3'd3);
    run(1, "t4");
    check_exp("t4_gap_at_min", R, Y, 3'd4);

    // A car pulse during HW_Y must not be remembered.
    do_reset();
    lr_has_car = 1'b1;
    run(80, "t4b");
    lr_has_car = 1'b0;
    run(5, "t4b");
    lr_has_car = 1'b1;
    run(1, "t4b");
    lr_has_car = 1'b0;
    run(300, "t4b");
    check_exp("t4_no_latch", G, R, 3'd0);

    // Reset mid LR_Y restarts the highway minimum.
    do_reset();
    lr_has_car = 1'b1;
    run(190, "t5");
    check_exp("t5_lr_y_t10", R, Y, 3'd4);
    rst_n = 1'b0;
    run(1, "t5");
    check_exp("t5_reset", G, R, 3'd0);
    rst_n = 1'b1;
    run(79, "t5");
    check_exp("t5_min_restart", G, R, 3'd0);
    run(1, "t5");
    check_exp("t5_yield", Y, R, 3'd1);

    // Night request.
    do_reset();
    night_req = 1'b1;
    run(80, "t6");
`ifdef TLC_NIGHT_FLASH_EN
    check_exp("t6_night_yield", Y, R, 3'd1);
    run(20, "t6");
    check_exp("t6_ar1", R, R, 3'd2);
    run(1, "t6");
    check_exp("t6_night_lit", Y, R, 3'd6);
    run(7, "t6");
    check_exp("t6_night_lit_end", Y, R, 3'd6);
    run(1, "t6");
    check_exp("t6_night_dark", D, D, 3'd6);
    run(8, "t6");
    check_exp("t6_night_relit", Y, R, 3'd6);
    night_req = 1'b0;
    run(1, "t6");
    check_exp("t6_exit_ar2", R, R, 3'd5);
    run(1, "t6");
    check_exp("t6_exit_hw_g", G, R, 3'd0);
`else
    check_exp("t6_night_ignored", G, R, 3'd0);
    run(100, "t6");
    check_exp("t6_night_ignored_long", G, R, 3'd0);
`endif
    night_req = 1'b0;

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 8) lr_has_car = ~lr_has_car;
      if ($urandom_range(0, 199) == 0) night_req = ~night_req;
      rst_n = ($urandom_range(0, 999) != 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
